best_arr_tx: RTL and testbench
==============================

// Module: best_arr_tx
// PURPOSE
//  Transmit side of the 11-bit pin stream. On send_best_arr, reads every 64-bit entry of the
//  best-match array over its read port and splits each entry into 11-bit words. The words are
//  written into the output FIFO write port, whose read side drives out_fifo_rdata on the pads.
//  Sits inside top, between the best array and the output FIFO. Runs in the accelerator clock domain.
// PARAMETERS
//  DATA_WIDTH   11   FIFO word width
//  ENTRY_WIDTH  64   best array entry width
//  NUM_ENTRIES  256  entries sent per transfer
//  ADDR_WIDTH   8    best array address width; 2**ADDR_WIDTH >= NUM_ENTRIES
//  (derived) NUM_CHUNKS = ceil(ENTRY_WIDTH/DATA_WIDTH) = 6
// PORTS
//  clk              in   1    accelerator clock
//  rst_n            in   1    asynchronous active-low reset
//  send_best_arr    in   1    start pulse; sampled only in IDLE
//  busy             out  1    high from the cycle after an accepted start through DONE
//  done             out  1    one-cycle pulse after the last word is enqueued
//  best_arr_csb1    out  1    best array read chip select, active low
//  best_arr_addr1   out  8    best array read address
//  best_arr_rdata1  in   64   read data; valid the cycle after csb1 is low
//  out_fifo_wenq    out  1    FIFO enqueue strobe
//  out_fifo_wdata   out  11   FIFO write data
//  out_fifo_wfull_n in   1    FIFO not-full; a word transfers on a clk edge with wenq=1
// BEHAVIOUR
//  Clock and reset:
//  - Single clock. Reset is asynchronous and active-low.
//  - Reset values: state=IDLE, busy=0, done=0, csb1=1, addr1=0, wenq=0, wdata=0, chunk counter=0.
//  FSM states and transitions:
//  - IDLE: send_best_arr=1 -> RD. Stay otherwise.
//  - RD: csb1=0 and addr1=entry index, for exactly one cycle -> LATCH.
//  - LATCH: capture rdata1 into a 66-bit shift register, zero-extended in bits [65:64].
//    Clear the chunk counter -> SEND.
//  - SEND: out_fifo_wenq = out_fifo_wfull_n (combinational). out_fifo_wdata = shreg[10:0].
//    - On an accepted word: shift right by 11 and increment the chunk counter.
//    - If wfull_n=0: hold wdata and the counter; no word is dropped or repeated.
//    - After chunk 5 is accepted: if index == NUM_ENTRIES-1 -> DONE; else index+1 -> RD.
//  - DONE: done=1 for one cycle, busy=0 -> IDLE. Index resets to 0.
//  Word order and width:
//  - Entry index ascending; within an entry, LSB chunk first.
//  - Chunk 5 carries bits [63:55] in wdata[8:0]; wdata[10:9]=0.
//  Timing:
//  - Accepted start at edge 0: RD in cycle 1; first wenq in cycle 3.
//  - Each entry takes 8 cycles with no stall (no read prefetch).
//  - Full transfer with no stall: last wenq in cycle 2048, done in cycle 2049.
//  Boundary cases:
//  - send_best_arr while busy, or during DONE, is ignored; it does not queue.
//  - wfull_n dropping on the cycle of the last chunk: the word waits; done is delayed by the stall.
//  - csb1 is high in every state except RD. The array is never read while SEND is stalled.
//  - Reset mid-transfer: immediate return to IDLE, no done pulse.
//    The next start restarts at index 0.
//  - wenq=0 whenever state != SEND.
// TESTING
//  1. Assert reset mid-cycle -> immediately csb1=1, wenq=0, busy=0, done=0, addr1=0.
//  2. Entry 0 = 64'h0123456789ABCDEF, wfull_n=1 -> words 0x5EF, 0x579, ... chunk5=0x002.
//     1536 words total; done in cycle 2049.
//  3. Hold wfull_n=0 for 5 cycles during chunk 2 of entry 3 -> wdata held stable.
//     The word sequence equals the no-stall run; done is 5 cycles later (2054).
//  4. Pulse send_best_arr again at cycle 100 while busy -> ignored: exactly one done, 1536 words.
//  5. Assert rst_n=0 during entry 10, then start again -> first read addr1=0.
//     Full 1536-word sequence; no done from the aborted run.
//  6. Random wfull_n (50%) over a full pass -> scoreboard matches all 256 entries.
//     csb1 is low exactly 256 cycles.

Source files
------------

// File: rtl/best_arr_tx.sv
// best_arr_tx: transmit side of the 11-bit pin stream.
// On a start pulse, reads every entry of the best-match array (one read per
// entry, no prefetch). Each entry is split into 11-bit words, LSB chunk first,
// and the words go to the output FIFO write port. The FIFO may stall the
// stream at any word without a word being lost or repeated.
//
// Handshake (FIFO write side): a word transfers on a rising clk edge where
// out_fifo_wenq=1. wenq is only ever raised while out_fifo_wfull_n=1.
// out_fifo_wdata stays stable while the FSM waits on out_fifo_wfull_n=0.
module best_arr_tx #(
  parameter int DATA_WIDTH  = 11,
  parameter int ENTRY_WIDTH = 64,
  parameter int NUM_ENTRIES = 256,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   send_best_arr,
  output logic                   busy,
  output logic                   done,
  output logic                   best_arr_csb1,
  output logic [ADDR_WIDTH-1:0]  best_arr_addr1,
  input  logic [ENTRY_WIDTH-1:0] best_arr_rdata1,
  output logic                   out_fifo_wenq,
  output logic [DATA_WIDTH-1:0]  out_fifo_wdata,
  input  logic                   out_fifo_wfull_n,
  output logic [2:0]             dbg_state
);

  // Number of FIFO words per entry and the width of the zero-extended
  // shift register that holds one entry while it is being sent.
  localparam int NUM_CHUNKS = (ENTRY_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int SHREG_W    = NUM_CHUNKS * DATA_WIDTH;
  localparam int CW         = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD    = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [CW-1:0]         LAST_CHUNK = CW'(NUM_CHUNKS - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ENTRY = ADDR_WIDTH'(NUM_ENTRIES - 1);

  logic [2:0]            state;
  logic [2:0]            state_nx;
  logic [ADDR_WIDTH-1:0] index;
  logic [CW-1:0]         chunk;
  logic [SHREG_W-1:0]    shreg;

  logic word_accepted;
  logic last_chunk;
  logic last_entry;

  assign word_accepted = (state == S_SEND) && out_fifo_wfull_n;
  assign last_chunk    = (chunk == LAST_CHUNK);
  assign last_entry    = (index == LAST_ENTRY);

  // Next-state decode; a start pulse is only looked at in IDLE, so a pulse
  // during a transfer or during DONE is simply dropped.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (send_best_arr) state_nx = S_RD;
      S_RD:    state_nx = S_LATCH;
      S_LATCH: state_nx = S_SEND;
      S_SEND: begin
        if (word_accepted && last_chunk) begin
          state_nx = last_entry ? S_DONE : S_RD;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register; reset aborts any transfer with no done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Entry index: advances after the last chunk of a non-final entry,
  // returns to 0 in DONE so the next transfer starts from entry 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index <= '0;
    end else if (state == S_DONE) begin
      index <= '0;
    end else if (word_accepted && last_chunk && !last_entry) begin
      index <= index + 1'b1;
    end
  end

  // Entry shift register and chunk counter: load on LATCH (read data is
  // valid the cycle after the RD strobe), shift one word per accepted word.
  // A stalled word leaves both untouched so the same word is re-offered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      chunk <= '0;
    end else if (state == S_LATCH) begin
      shreg <= {{(SHREG_W - ENTRY_WIDTH){1'b0}}, best_arr_rdata1};
      chunk <= '0;
    end else if (word_accepted) begin
      shreg <= shreg >> DATA_WIDTH;
      chunk <= chunk + 1'b1;
    end
  end

  // Output decode: all strobes come straight from the state so the array
  // is read exactly once per entry and never while SEND is stalled.
  always_comb begin
    busy           = (state == S_RD) || (state == S_LATCH) || (state == S_SEND);
    done           = (state == S_DONE);
    best_arr_csb1  = (state != S_RD);
    best_arr_addr1 = index;
    out_fifo_wenq  = word_accepted;
    out_fifo_wdata = (state == S_SEND) ? shreg[DATA_WIDTH-1:0] : '0;
    dbg_state      = state;
  end

endmodule

// File: tb/tb_best_arr_tx.sv
// tb_best_arr_tx: randomized scoreboard bench for best_arr_tx.
// A behavioural model of the best array answers reads; the expected word
// stream is derived from the array contents by plain shifts and pushed into
// exp_q before each transfer. A negedge monitor pops and compares every
// word the DUT enqueues.
module tb_best_arr_tx;

  localparam int DW = 11;
  localparam int EW = 64;
  localparam int NE = 256;
  localparam int AW = 8;
  localparam int NC = 6;

  logic          clk;
  logic          rst_n;
  logic          send_best_arr;
  logic          busy;
  logic          done;
  logic          best_arr_csb1;
  logic [AW-1:0] best_arr_addr1;
  logic [EW-1:0] best_arr_rdata1;
  logic          out_fifo_wenq;
  logic [DW-1:0] out_fifo_wdata;
  logic          out_fifo_wfull_n;
  logic [2:0]    dbg_state;

  best_arr_tx #(
    .DATA_WIDTH(DW), .ENTRY_WIDTH(EW), .NUM_ENTRIES(NE), .ADDR_WIDTH(AW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .send_best_arr   (send_best_arr),
    .busy            (busy),
    .done            (done),
    .best_arr_csb1   (best_arr_csb1),
    .best_arr_addr1  (best_arr_addr1),
    .best_arr_rdata1 (best_arr_rdata1),
    .out_fifo_wenq   (out_fifo_wenq),
    .out_fifo_wdata  (out_fifo_wdata),
    .out_fifo_wfull_n(out_fifo_wfull_n),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared state ----------------
  logic [EW-1:0] mem [NE];
  logic [DW-1:0] exp_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int c0 = 0;
  int acc = 0;
  int done_cnt = 0;
  int done_cycle = -1;
  int first_wenq = -1;
  int csb_low = 0;
  int exp_addr = 0;
  int mode = 0;        // 0: FIFO always ready, 1: random, 2: scripted stall
  bit stall_used = 0;
  int stall_left = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // ---------------- best array model ----------------
  initial best_arr_rdata1 = '0;
  always @(posedge clk) begin
    if (!best_arr_csb1) best_arr_rdata1 <= mem[best_arr_addr1];
  end

  // ---------------- FIFO full driver ----------------
  initial begin
    out_fifo_wfull_n = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        1: out_fifo_wfull_n = 1'($urandom_range(0, 1));
        2: begin
          if (stall_left > 0) begin
            out_fifo_wfull_n = 1'b0;
            stall_left--;
          end else if (!stall_used && acc == 3 * NC + 2) begin
            // chunk 2 of entry 3 is now on the bus: refuse it for 5 cycles
            stall_used = 1;
            stall_left = 4;
            out_fifo_wfull_n = 1'b0;
          end else begin
            out_fifo_wfull_n = 1'b1;
          end
        end
        default: out_fifo_wfull_n = 1'b1;
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      int cnow;
      cnow = cyc - c0 + 1;
      if (!best_arr_csb1) begin
        chk("read_addr", 64'(best_arr_addr1), 64'(exp_addr));
        exp_addr++;
        csb_low++;
      end
      if (out_fifo_wenq) begin
        if (first_wenq < 0) first_wenq = cnow;
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 64'(out_fifo_wdata), 64'h7ff_dead);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          chk("word", 64'(out_fifo_wdata), 64'(e));
        end
        acc++;
      end else if (dbg_state == 3'd3 && exp_q.size() > 0) begin
        // stalled: the pending word must be held on the bus
        chk("stall_hold", 64'(out_fifo_wdata), 64'(exp_q[0]));
      end
      if (done) begin
        done_cnt++;
        done_cycle = cnow;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic fill_mem();
    for (int e = 0; e < NE; e++) mem[e] = {$urandom, $urandom};
    mem[0]    = 64'h0123456789ABCDEF;
    mem[NE-1] = '1;
  endtask

  task automatic push_expected();
    exp_q.delete();
    for (int e = 0; e < NE; e++)
      for (int k = 0; k < NC; k++)
        exp_q.push_back(DW'(mem[e] >> (DW * k)));
  endtask

  task automatic start_pass(input int pmode);
    mode = pmode;
    stall_used = 0;
    stall_left = 0;
    push_expected();
    acc = 0; done_cnt = 0; csb_low = 0; exp_addr = 0;
    first_wenq = -1; done_cycle = -1;
    @(posedge clk); #1;
    send_best_arr = 1'b1;
    @(posedge clk); #1;        // edge 0
    c0 = cyc;
    send_best_arr = 1'b0;
    chk("busy_cycle1", 64'(busy), 64'd1);
  endtask

  task automatic run_pass(input int pmode, input bit extra, input int exp_done);
    bit got;
    start_pass(pmode);
    got = 0;
    for (int i = 0; i < 6000 && !got; i++) begin
      @(posedge clk); #1;
      send_best_arr = extra && ((cyc - c0 + 1) == 100);
      got = (done_cnt > 0);
    end
    send_best_arr = 1'b0;
    if (!got) chk("done_timeout", 64'd0, 64'd1);
    mode = 0;
    repeat (20) @(posedge clk);
    #1;
    chk("done_count", 64'(done_cnt), 64'd1);
    chk("words_left", 64'(exp_q.size()), 64'd0);
    chk("words_sent", 64'(acc), 64'(NE * NC));
    chk("csb_low_cycles", 64'(csb_low), 64'(NE));
    chk("busy_after_done", 64'(busy), 64'd0);
    if (pmode != 1) chk("first_wenq_cycle", 64'(first_wenq), 64'd3);
    if (exp_done > 0) chk("done_cycle", 64'(done_cycle), 64'(exp_done));
  endtask

  task automatic abort_pass();
    start_pass(0);
    for (int i = 0; i < 2000 && acc < 10 * NC + 2; i++) begin
      @(posedge clk); #1;
    end
    chk("reached_entry10", 64'(acc >= 10 * NC + 2), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_csb1", 64'(best_arr_csb1), 64'd1);
    chk("abort_wenq", 64'(out_fifo_wenq), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_addr", 64'(best_arr_addr1), 64'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_done", 64'(done_cnt), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    send_best_arr = 1'b0;
    fill_mem();
    #7;
    chk("rst_csb1", 64'(best_arr_csb1), 64'd1);
    chk("rst_wenq", 64'(out_fifo_wenq), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_addr", 64'(best_arr_addr1), 64'd0);
    chk("rst_wdata", 64'(out_fifo_wdata), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_pass(0, 1'b0, 2049);          // plain transfer
    run_pass(2, 1'b0, 2054);          // 5-cycle stall on chunk 2 of entry 3
    run_pass(0, 1'b1, 2049);          // second start while busy is ignored
    abort_pass();                     // reset during entry 10
    run_pass(0, 1'b0, 2049);          // restart from entry 0
    fill_mem();
    run_pass(1, 1'b0, 0);             // random backpressure

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout actual=running required=finished");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

endmodule
